// File: rtl/mult_share_arbiter_pkg.sv
//------------------------------------------------------------------------------
// mult_pkg : shared defaults, clog2 helper and result tag type
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

    localparam int DEF_N    = 16;
    localparam int DEF_NREQ = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef logic [clog2(DEF_NREQ)-1:0] tag_t;

endpackage

`default_nettype wire

// File: rtl/mult_share_arbiter_if.sv
//------------------------------------------------------------------------------
// mult_share_arbiter_if : requester and result handshake bundle
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mult_share_arbiter_if
    import mult_pkg::*;
#(
    parameter int n    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = clog2(DEF_NREQ),
    parameter int CNTW = 16
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*n-1:0] req_a;
    logic [NREQ*n-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [2*n-1:0]    res_z;
    logic [IDW-1:0]    res_id;
    logic [CNTW-1:0]   done_cnt;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_z, res_id, done_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_z, res_id, done_cnt
    );

endinterface

`default_nettype wire

// File: rtl/mult_share_arbiter_mul.sv
//------------------------------------------------------------------------------
// multiplyOperator : combinational unsigned n x n -> 2n multiplier
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multiplyOperator #(
    parameter int n = 16
) (
    input  wire logic [n-1:0]   A,
    input  wire logic [n-1:0]   B,
    output logic      [2*n-1:0] Z
);

    assign Z = {{n{1'b0}}, A} * {{n{1'b0}}, B};

endmodule

`default_nettype wire

// File: rtl/mult_share_arbiter_rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, cyclic scan starting at ptr
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = clog2(DEF_NREQ)
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IDW-1:0]  ptr,
    input  wire logic            en,
    output logic      [NREQ-1:0] gnt,
    output logic      [IDW-1:0]  gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_share_arbiter.sv
//------------------------------------------------------------------------------
// mult_share_arbiter : shares one multiplier among NREQ requesters (round robin,
//                      one registered result stage tagged with requester id)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int n    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = clog2(NREQ),
    parameter int CNTW = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    mult_share_arbiter_if.slave   bus
);

    logic            w_slot_free;
    logic            w_en;
    logic            w_accept;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_ptr_next;
    logic [n-1:0]    w_a;
    logic [n-1:0]    w_b;
    logic [2*n-1:0]  w_z;

    logic            r_res_valid;
    logic [2*n-1:0]  r_res_z;
    logic [IDW-1:0]  r_res_id;
    logic [IDW-1:0]  r_rr_ptr;
    logic [CNTW-1:0] r_done_cnt;

    // Reset gates the arbiter so req_ready is held low while rst_n is low.
    assign w_slot_free = !r_res_valid || bus.res_ready;
    assign w_en        = rst_n && w_slot_free;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (r_rr_ptr),
        .en      (w_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_accept   = |(bus.req_valid & w_gnt);
    assign w_a        = bus.req_a[w_gnt_idx*n +: n];
    assign w_b        = bus.req_b[w_gnt_idx*n +: n];
    assign w_ptr_next = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;

    multiplyOperator #(
        .n (n)
    ) u_mul (
        .A (w_a),
        .B (w_b),
        .Z (w_z)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_z     <= '0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
            r_done_cnt  <= '0;
        end else begin
            if (r_res_valid && bus.res_ready) begin
                r_done_cnt <= r_done_cnt + 1'b1;
            end
            // A same-cycle accept overwrites the departing result.
            if (w_accept) begin
                r_res_valid <= 1'b1;
                r_res_z     <= w_z;
                r_res_id    <= w_gnt_idx;
                r_rr_ptr    <= w_ptr_next;
            end else if (bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.res_valid = r_res_valid;
    assign bus.res_z     = r_res_z;
    assign bus.res_id    = r_res_id;
    assign bus.done_cnt  = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
//------------------------------------------------------------------------------
// tb_mult_share_arbiter : directed scenarios plus random traffic vs. a model
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_share_arbiter;

    localparam int N    = 16;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mult_share_arbiter_if #(.n(N), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus ();

    mult_share_arbiter #(.n(N), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: what the result register, pointer and counter must hold.
    bit          m_on  = 1'b0;
    bit          m_valid;
    logic [31:0] m_z;
    int          m_id;
    int          m_ptr;
    int          m_cnt;
    int          m_acc = -1;

    function automatic int exp_grant();
        int i;
        if (!rst_n) return -1;
        if (m_valid && !bus.res_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        int g;
        logic [N-1:0] a;
        logic [N-1:0] b;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_valid = 1'b0;
                m_z     = '0;
                m_id    = 0;
                m_ptr   = 0;
                m_cnt   = 0;
                m_acc   = -1;
            end else begin
                g = exp_grant();
                if (m_valid && bus.res_ready) m_cnt = (m_cnt + 1) % (1 << CNTW);
                if (g >= 0) begin
                    a       = bus.req_a[g*N +: N];
                    b       = bus.req_b[g*N +: N];
                    m_z     = 32'(a) * 32'(b);
                    m_id    = g;
                    m_valid = 1'b1;
                    m_ptr   = (g + 1) % NREQ;
                end else if (bus.res_ready) begin
                    m_valid = 1'b0;
                end
                m_acc = g;
            end
            m_on = 1'b1;
        end
    end

    initial begin
        int g;
        logic [NREQ-1:0] e;
        forever begin
            @(negedge clk);
            if (m_on) begin
                g = exp_grant();
                e = '0;
                if (g >= 0) e[g] = 1'b1;
                chk("cmp_req_ready", 64'(bus.req_ready), 64'(e));
                chk("cmp_res_valid", 64'(bus.res_valid), 64'(m_valid));
                chk("cmp_res_z",     64'(bus.res_z),     64'(m_z));
                chk("cmp_res_id",    64'(bus.res_id),    64'(m_id));
                chk("cmp_done_cnt",  64'(bus.done_cnt),  64'(m_cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.req_valid[i]     = 1'b1;
        bus.req_a[i*N +: N]  = a;
        bus.req_b[i*N +: N]  = b;
    endtask

    function automatic logic [N-1:0] rnd_op();
        case ($urandom % 8)
            0:       return '0;
            1:       return '1;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        int t2z [4] = '{880, 640, 1024, 1200};
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_z",     64'(bus.res_z),     64'd0);
        chk("rst_done_cnt",  64'(bus.done_cnt),  64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;

        // Single requester
        set_req(0, 16'd30, 16'd150);
        bus.res_ready = 1'b1;
        #1 chk("t1_req_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid[0] = 1'b0;
        chk("t1_res_valid", 64'(bus.res_valid), 64'd1);
        chk("t1_res_z",     64'(bus.res_z),     64'd4500);
        chk("t1_res_id",    64'(bus.res_id),    64'd0);
        chk("t1_model_z",   64'(m_z),           64'd4500);
        tick();
        chk("t1_done_cnt",  64'(bus.done_cnt),  64'd1);
        chk("t1_res_idle",  64'(bus.res_valid), 64'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // All four at once, ordered grants
        set_req(0, 16'd110, 16'd8);
        set_req(1, 16'd20,  16'd32);
        set_req(2, 16'd512, 16'd2);
        set_req(3, 16'd120, 16'd10);
        bus.res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk("t2_req_ready", 64'(bus.req_ready), 64'(4'b0001 << c));
            tick();
            bus.req_valid[c] = 1'b0;
            chk("t2_res_z",  64'(bus.res_z),  64'(t2z[c]));
            chk("t2_res_id", 64'(bus.res_id), 64'(c));
        end
        chk("t2_done_cnt", 64'(bus.done_cnt), 64'd3);

        // Backpressure
        tick();
        set_req(0, 16'd30, 16'd150);
        bus.res_ready = 1'b0;
        tick();
        bus.req_valid[0] = 1'b0;
        set_req(1, 16'd7, 16'd9);
        for (int c = 0; c < 3; c++) begin
            #1 chk("t3_req_ready_held", 64'(bus.req_ready), 64'd0);
            chk("t3_res_z_held", 64'(bus.res_z), 64'd4500);
            tick();
        end
        bus.res_ready = 1'b1;
        #1 chk("t3_req_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid[1] = 1'b0;
        chk("t3_res_z",     64'(bus.res_z),     64'd63);
        chk("t3_res_id",    64'(bus.res_id),    64'd1);
        chk("t3_done_cnt",  64'(bus.done_cnt),  64'd5);
        chk("t3_model_cnt", 64'(m_cnt),         64'd5);

        // Round-robin pointer after r2
        set_req(2, 16'd3, 16'd5);
        tick();
        bus.req_valid[2] = 1'b0;
        chk("t4_r2_z", 64'(bus.res_z), 64'd15);
        set_req(0, 16'd11, 16'd13);
        set_req(3, 16'd17, 16'd19);
        #1 chk("t4_gnt_r3", 64'(bus.req_ready), 64'h8);
        tick();
        bus.req_valid[3] = 1'b0;
        chk("t4_id_r3", 64'(bus.res_id), 64'd3);
        chk("t4_z_r3",  64'(bus.res_z),  64'd323);
        #1 chk("t4_gnt_r0", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid[0] = 1'b0;
        chk("t4_id_r0", 64'(bus.res_id), 64'd0);
        chk("t4_z_r0",  64'(bus.res_z),  64'd143);

        // Operand boundaries
        set_req(1, 16'hFFFF, 16'hFFFF);
        tick();
        bus.req_valid[1] = 1'b0;
        chk("t5_max_z", 64'(bus.res_z), 64'hFFFE0001);
        set_req(2, 16'h0000, 16'h1234);
        tick();
        bus.req_valid[2] = 1'b0;
        chk("t5_zero_z", 64'(bus.res_z), 64'd0);
        chk("t5_zero_valid", 64'(bus.res_valid), 64'd1);

        // Reset with a result pending
        bus.res_ready = 1'b0;
        set_req(3, 16'd5, 16'd5);
        tick();
        rst_n = 1'b0;
        #1 chk("t6_req_ready_rst", 64'(bus.req_ready), 64'd0);
        tick();
        chk("t6_res_valid", 64'(bus.res_valid), 64'd0);
        chk("t6_done_cnt",  64'(bus.done_cnt),  64'd0);
        set_req(0, 16'd2, 16'd2);
        rst_n = 1'b1;
        #1 chk("t6_first_gnt", 64'(bus.req_ready), 64'h1);
        bus.res_ready = 1'b1;
        tick();
        bus.req_valid[0] = 1'b0;
        chk("t6_res_id", 64'(bus.res_id), 64'd0);
        chk("t6_res_z",  64'(bus.res_z),  64'd4);
        tick();
        bus.req_valid[3] = 1'b0;
        tick();

        // Random traffic; requesters hold operands until accepted
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_acc == i) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i] && ($urandom % 4 == 0)) set_req(i, rnd_op(), rnd_op());
            end
            bus.res_ready = ($urandom % 4) != 0;
            rst_n         = ($urandom % 250) != 0;
            tick();
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
